// File: rtl/microcode_sequencer.sv
// microcode_sequencer: micro-PC and next-address logic for a one-cycle-latency microcode ROM; MICROSEQ_PERF_EN adds a retired-word counter
module microcode_sequencer #(
  parameter  int WORD_SIZE = 16,
  parameter  int ROM_SIZE  = 1024,
  parameter  int RESET_VEC = 0,
  localparam int ADDR_W    = $clog2(ROM_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef MICROSEQ_PERF_EN
  output logic [15:0]          perf_retired_o,
`endif
  output logic [ADDR_W-1:0]    rom_addr_o,
  input  logic [WORD_SIZE-1:0] rom_data_i,
  input  logic                 stall_i,
  input  logic                 cond_i,
  input  logic [7:0]           opcode_i,
  input  logic                 opcode_valid_i,
  output logic                 opcode_ack_o,
  output logic [WORD_SIZE-3:0] ctrl_o,
  output logic                 ctrl_valid_o,
  output logic [ADDR_W-1:0]    upc_o
);
  typedef enum logic [1:0] {PRIME, RUN, WAIT_OP} state_t;
  localparam logic [1:0] OP_JUMP = 2'b01, OP_BRANCH = 2'b10, OP_DISPATCH = 2'b11;
  localparam logic [ADDR_W-1:0] RV = ADDR_W'(RESET_VEC);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] upc_q, upc_d, seq_addr, upc_inc, target, slot_addr;
  logic [1:0] op;
  logic run_go, take_op;
  assign op        = rom_data_i[WORD_SIZE-1 -: 2];
  assign target    = rom_data_i[ADDR_W-1:0];
  assign upc_inc   = (upc_q == ADDR_W'(ROM_SIZE-1)) ? '0 : upc_q + 1'b1;
  assign slot_addr = ADDR_W'({opcode_i, 2'b00});
  assign run_go    = (state_q == RUN) && !stall_i;
  assign take_op   = (state_q == WAIT_OP) && opcode_valid_i && !stall_i;
  // Next-address mux on the ROM output; a dispatch parks on its own address while waiting
  always_comb seq_addr = (op == OP_JUMP || (op == OP_BRANCH && cond_i)) ? target :
                         (op == OP_DISPATCH) ? upc_q : upc_inc;
  // Next state and micro-PC; the ROM is always addressed with the word that will execute next
  always_comb begin
    upc_d   = (state_q == PRIME) ? RV : run_go ? seq_addr : take_op ? slot_addr : upc_q;
    state_d = (state_q == PRIME) ? RUN :
              (run_go && op == OP_DISPATCH) ? WAIT_OP :
              take_op ? RUN : state_q;
  end
  // State and micro-PC registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= PRIME;
      upc_q   <= RV;
    end else begin
      state_q <= state_d;
      upc_q   <= upc_d;
    end
  assign rom_addr_o   = upc_d;
  assign upc_o        = upc_q;
  assign ctrl_valid_o = run_go;
  assign opcode_ack_o = take_op;
  assign ctrl_o       = run_go ? rom_data_i[WORD_SIZE-3:0] : '0;
`ifdef MICROSEQ_PERF_EN
  logic [15:0] perf_q, perf_d;
  always_comb perf_d = (run_go && perf_q != 16'hFFFF) ? perf_q + 16'd1 : perf_q;
  // Saturating count of retired microwords
  always_ff @(posedge clk or posedge rst)
    if (rst) perf_q <= '0;
    else perf_q <= perf_d;
  assign perf_retired_o = perf_q;
`endif
endmodule

// File: tb/tb_microcode_sequencer.sv
// tb_microcode_sequencer: random and directed checks of the sequencer against a program-level model with a bench-side ROM
module tb_microcode_sequencer;
  logic clk = 0, rst = 1;
  logic [9:0] rom_addr, upc;
  logic [15:0] rom_data;
  logic stall = 0, cond = 0, opv = 0, ack;
  logic [7:0] opc = 0;
  logic [13:0] ctrl;
  logic ctrl_valid;
`ifdef MICROSEQ_PERF_EN
  logic [15:0] perf;
`endif
  logic [15:0] rom [1024];
  int vecs = 0, errs = 0, m_ph = 0, m_upc = 0, m_ret = 0, acks = 0;
  microcode_sequencer dut (
    .clk(clk), .rst(rst),
`ifdef MICROSEQ_PERF_EN
    .perf_retired_o(perf),
`endif
    .rom_addr_o(rom_addr), .rom_data_i(rom_data), .stall_i(stall), .cond_i(cond),
    .opcode_i(opc), .opcode_valid_i(opv), .opcode_ack_o(ack), .ctrl_o(ctrl),
    .ctrl_valid_o(ctrl_valid), .upc_o(upc));
  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] w(input int op, input int lo);
    logic [1:0] o2 = op[1:0];
    logic [13:0] l14 = lo[13:0];
    return {o2, l14};
  endfunction
  // Where the program goes next, from the microword at the model's PC
  function automatic int exp_addr(input logic s, input logic c, input logic v, input logic [7:0] o);
    int op, tgt, inc;
    if (m_ph == 0) return 0;
    if (s) return m_upc;
    if (m_ph == 2) return v ? int'(o) * 4 : m_upc;
    op = int'(rom[m_upc]) / 16384;
    tgt = int'(rom[m_upc]) % 1024;
    inc = (m_upc + 1) % 1024;
    if (op == 0) return inc;
    if (op == 1) return tgt;
    if (op == 2) return c ? tgt : inc;
    return m_upc;
  endfunction
  task automatic tick(input logic s, input logic c, input logic v, input logic [7:0] o);
    int ea;
    logic ev, ea_ack;
    stall = s; cond = c; opv = v; opc = o;
    @(negedge clk);
    ea = exp_addr(s, c, v, o);
    ev = (m_ph == 1) && !s;
    ea_ack = (m_ph == 2) && v && !s;
    chk("rom_addr", 32'(rom_addr), ea);
    chk("ctrl_valid", 32'(ctrl_valid), 32'(ev));
    chk("ctrl_out", 32'(ctrl), ev ? int'(rom[m_upc]) % 16384 : 0);
    chk("opcode_ack", 32'(ack), 32'(ea_ack));
    chk("upc", 32'(upc), m_upc);
`ifdef MICROSEQ_PERF_EN
    chk("perf", 32'(perf), m_ret);
`endif
    if (ea_ack) acks++;
    if (ev && m_ret < 65535) m_ret++;
    @(posedge clk); #1;
    if (m_ph == 0) begin m_ph = 1; m_upc = 0; end
    else if (ev) begin
      if (int'(rom[m_upc]) / 16384 == 3) m_ph = 2;
      else m_upc = ea;
    end else if (ea_ack) begin m_ph = 1; m_upc = ea; end
  endtask
  task automatic do_reset();
    rst = 1; stall = 0; opv = 0;
    @(posedge clk); #1;
    chk("rst_addr", 32'(rom_addr), 0);
    chk("rst_valid", 32'(ctrl_valid), 0);
    chk("rst_upc", 32'(upc), 0);
    rst = 0; m_ph = 0; m_upc = 0; m_ret = 0;
`ifdef MICROSEQ_PERF_EN
    chk("rst_perf", 32'(perf), 0);
`endif
  endtask
  task automatic fill_next();
    for (int i = 0; i < 1024; i++) rom[i] = w(0, int'($urandom_range(0, 16383)));
  endtask
  initial begin
    fill_next();
    do_reset();
    repeat (4) tick(0, 0, 0, 0);
    // wrap from the last ROM word
    rom[0] = w(1, 1023);
    do_reset();
    repeat (4) tick(0, 0, 0, 0);
    // branch taken / not taken
    rom[0] = w(1, 'h10); rom[16] = w(2, 'h40);
    for (int c = 1; c >= 0; c--) begin
      do_reset();
      tick(0, 0, 0, 0); tick(0, 0, 0, 0); tick(0, c[0], 0, 0);
      chk("branch_upc", 32'(upc), c ? 'h40 : 'h11);
      tick(0, 0, 0, 0);
    end
    // dispatch with delayed opcode
    rom[0] = w(1, 5); rom[5] = w(3, 'h1234);
    do_reset();
    acks = 0;
    repeat (3) tick(0, 0, 0, 0);
    repeat (3) tick(0, 0, 0, 8'hA9);
    tick(0, 0, 1, 8'hA9);
    chk("slot_upc", 32'(upc), 'h2A4);
    tick(0, 0, 0, 0);
    chk("ack_count", acks, 1);
    // stall in WAIT_OP beats opcode_valid
    do_reset();
    acks = 0;
    repeat (3) tick(0, 0, 0, 0);
    repeat (2) tick(1, 0, 1, 8'h3C);
    chk("stall_no_ack", acks, 0);
    tick(0, 0, 1, 8'h3C);
    tick(0, 0, 0, 0);
    // stall in RUN
    rom[0] = w(1, 'h20); rom['h20] = w(0, 'h2AAA);
    do_reset();
    tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    repeat (2) tick(1, 0, 0, 0);
    tick(0, 0, 0, 0); tick(0, 0, 0, 0);
    // asynchronous reset while an opcode is being acknowledged
    rom[0] = w(1, 5);
    do_reset();
    repeat (3) tick(0, 0, 0, 0);
    opv = 1; opc = 8'h77; #1;
    chk("pre_rst_ack", 32'(ack), 1);
    rst = 1; #1;
    chk("async_ack", 32'(ack), 0);
    chk("async_valid", 32'(ctrl_valid), 0);
    chk("async_ctrl", 32'(ctrl), 0);
    chk("async_addr", 32'(rom_addr), 0);
    chk("async_upc", 32'(upc), 0);
    do_reset();
    repeat (3) tick(0, 0, 0, 0);
    // random programs and inputs
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 1024; i++) begin
        int r = int'($urandom_range(0, 9));
        rom[i] = w(r < 5 ? 0 : r < 7 ? 1 : r < 9 ? 2 : 3, int'($urandom_range(0, 16383)));
      end
      do_reset();
      for (int n = 0; n < 800; n++) begin
        if ($urandom_range(0, 199) == 0) do_reset();
        tick($urandom_range(0, 4) == 0, 1'($urandom), $urandom_range(0, 2) == 0, 8'($urandom));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/microcode_sequencer.md
# microcode_sequencer

Micro-program counter and next-address logic for the 6502 core. It drives the address input of the synchronous microcode ROM (one-cycle read latency) and consumes the ROM's data word. The low bits of that word go to the datapath as control signals; the top two bits select the next micro-address. On an opcode dispatch it waits for the instruction register, then jumps to a four-word slot per opcode.

## Interface
- `WORD_SIZE`, 16: microword width. Must match the ROM.
- `ROM_SIZE`, 1024: microcode depth. Must be ≥ 1024; `ADDR_W` = `$clog2(ROM_SIZE)`.
- `RESET_VEC`, 0: micro-address fetched after reset.
- `clk`  in  1: single clock. All state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `rom_addr`  out  ADDR_W: combinational address to the ROM.
- `rom_data`  in  WORD_SIZE: ROM word for the address presented on the previous edge.
- `stall`  in  1: hold the current microinstruction.
- `cond_in`  in  1: branch condition from the datapath.
- `opcode`  in  8: instruction-register opcode.
- `opcode_valid`  in  1: `opcode` is valid.
- `opcode_ack`  out  1: one-cycle pulse; the opcode was taken.
- `ctrl_out`  out  WORD_SIZE-2: datapath control bits.
- `ctrl_valid`  out  1: `ctrl_out` is live this cycle.
- `upc`  out  ADDR_W: address of the word currently on `rom_data`.

## Operation
- Microword fields:
  - Sequencing op: `rom_data[WORD_SIZE-1:WORD_SIZE-2]`.
  - Control bits: `rom_data[WORD_SIZE-3:0]`.
  - Target address: `rom_data[ADDR_W-1:0]`. This field overlaps the control bits; it is read only by JUMP and BRANCH.
- Sequencing ops:
  - 00 NEXT: next = upc+1, modulo ROM_SIZE. `ROM_SIZE-1` wraps to 0.
  - 01 JUMP: next = target.
  - 10 BRANCH: next = target if `cond_in`, else upc+1. `cond_in` is sampled in the executing cycle.
  - 11 DISPATCH: the control bits execute, then the state moves to WAIT_OP.
- States:
  - PRIME: `rom_addr`=RESET_VEC. Next state RUN, with upc←RESET_VEC.
  - RUN, `stall`=0: `ctrl_valid`=1. `rom_addr`=computed next address; upc←next. DISPATCH → WAIT_OP with upc unchanged.
  - RUN, `stall`=1: `ctrl_valid`=0. `rom_addr`=upc, which re-reads the same word. State and upc hold.
  - WAIT_OP: `ctrl_valid`=0.
    - `opcode_valid`=1 and `stall`=0: `rom_addr`={opcode,2'b00} zero-extended to ADDR_W. `opcode_ack`=1; upc←that address; next state RUN.
    - Otherwise: `rom_addr`=upc and the state holds.
- `ctrl_out` = `rom_data[WORD_SIZE-3:0]` when `ctrl_valid`, else all zeros. It is combinational.
- When `stall` and `opcode_valid` are both high in WAIT_OP, `stall` wins: no ack, no dispatch.

## Timing
- Reset values: state=PRIME, upc=RESET_VEC, `ctrl_valid`=0, `opcode_ack`=0, `ctrl_out`=0. While reset is held, `rom_addr`=RESET_VEC.
- Reset asserted mid-operation:
  - Outputs take their reset values immediately, without waiting for an edge.
  - After release, the first valid control word comes 1 edge later, from RESET_VEC.
- Throughput: one microinstruction per cycle in RUN with no stall.
- Latency: `rom_addr` at edge N produces `rom_data` at edge N+1.
- Dispatch: the dispatch word executes in cycle N. Earliest ack is cycle N+1. The slot word executes in cycle N+2.
- `opcode_ack` is combinational and high only in the handshake cycle. The instruction register may change `opcode` after that edge.
- Critical path: ROM output → next-address mux → `rom_addr`. There is no register between them.

## Configuration
- `MICROSEQ_PERF_EN` defined:
  - Adds output `perf_retired` (16 bits).
  - It counts cycles with `ctrl_valid`=1 and saturates at 0xFFFF.
  - Cleared by `rst`.
- `MICROSEQ_PERF_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset release, RESET_VEC=0, ROM[0..2] = NEXT: `rom_addr` sequence is 0,1,2,3. `ctrl_valid` first goes high in the cycle after release, with `upc`=0.
- Wrap: ROM[1023]=NEXT → upc goes 1023 then 0. `ctrl_out` follows ROM[0].
- BRANCH at 0x010 with target 0x040:
  - `cond_in`=1 → next upc = 0x040.
  - `cond_in`=0 → next upc = 0x011.
- DISPATCH at 0x005, then `opcode_valid` rises 3 cycles later with `opcode`=0xA9:
  - `ctrl_valid`=0 while waiting.
  - Exactly one `opcode_ack`.
  - `rom_addr`=0x2A4, then upc=0x2A4 with `ctrl_valid`=1.
- `stall` held 2 cycles in RUN at upc=0x020: `rom_addr` stays 0x020 and `ctrl_valid`=0 for 2 cycles, then execution resumes at 0x020 and `ctrl_valid` returns to 1.
  - Same in WAIT_OP with `opcode_valid`=1 and `stall`=1: no ack until `stall` drops.
- Reset asserted mid-dispatch wait: `ctrl_valid`, `opcode_ack` and `ctrl_out` go to 0 with no edge. The sequence restarts at RESET_VEC.
  - With `MICROSEQ_PERF_EN`: `perf_retired` reads 0 after reset.
